// File: rtl/dma_cg_pkg.sv
// Shared state codes and constants for the DMA clock-gate controller.
package dma_cg_pkg;

   typedef enum logic [1:0] {
      CG_OFF   = 2'd0,
      CG_WAKE  = 2'd1,
      CG_ON    = 2'd2,
      CG_DRAIN = 2'd3
   } cg_state_e;

   localparam int unsigned STAT_W       = 32;
   localparam int unsigned WAKE_W       = 8;
   localparam int unsigned WAKE_CYC_MIN = 1;
   localparam int unsigned WAKE_CYC_MAX = 255;

   function automatic bit wake_cyc_legal(int unsigned cyc);
      return (cyc >= WAKE_CYC_MIN) && (cyc <= WAKE_CYC_MAX);
   endfunction

endpackage

// File: rtl/dma_cg_stat_cnt.sv
// Saturating event counter with synchronous clear; clear takes priority over increment.
module dma_cg_stat_cnt #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/dma_clk_gate_ctrl.sv
// Sequences the DMA clock-gater enable: wake on request, ack once stable, gate off after idle.
// Define CLKGATE_STATS_EN to build the gated-off cycle counter (off_cycles).
module dma_clk_gate_ctrl
   import dma_cg_pkg::*;
#(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned WAKE_CYC = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_REQ-1:0]  req,
   input  logic [N_REQ-1:0]  busy,
   input  logic              force_on,
   input  logic [CNT_W-1:0]  idle_thresh,
   output logic [N_REQ-1:0]  ack,
   output logic              gate_en,
   output logic [1:0]        cg_state,
   input  logic              stat_clr,
   output logic [STAT_W-1:0] off_cycles
);

   if (!wake_cyc_legal(WAKE_CYC)) begin : g_wake_cyc_check
      $error("dma_clk_gate_ctrl: WAKE_CYC out of range 1..255");
   end

   localparam logic [WAKE_W-1:0] WakeLoad = WAKE_W'(WAKE_CYC - 1);

   cg_state_e          state_q, state_d;
   logic [WAKE_W-1:0]  wake_cnt_q, wake_cnt_d;
   logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic               gate_en_q, gate_en_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic               wake_req;
   logic               idle;

   assign wake_req = (|req) | force_on;
   assign idle     = ~(|req) & ~(|busy) & ~force_on;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CG_OFF;
         wake_cnt_q <= '0;
         idle_cnt_q <= '0;
         gate_en_q  <= 1'b0;
         ack_q      <= '0;
      end else begin
         state_q    <= state_d;
         wake_cnt_q <= wake_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         gate_en_q  <= gate_en_d;
         ack_q      <= ack_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wake_cnt_d = wake_cnt_q;
      idle_cnt_d = idle_cnt_q;
      unique case (state_q)
         CG_OFF: begin
            if (wake_req) begin
               state_d    = CG_WAKE;
               wake_cnt_d = WakeLoad;
            end
         end
         CG_WAKE: begin
            // Wake runs to completion even if requests drop meanwhile.
            if (wake_cnt_q == '0) begin
               state_d    = CG_ON;
               idle_cnt_d = idle_thresh;
            end else begin
               wake_cnt_d = wake_cnt_q - WAKE_W'(1);
            end
         end
         CG_ON: begin
            if (!idle) begin
               idle_cnt_d = idle_thresh;
            end else if (idle_cnt_q != '0) begin
               idle_cnt_d = idle_cnt_q - CNT_W'(1);
            end else begin
               state_d = CG_DRAIN;
            end
         end
         CG_DRAIN: begin
            // Clock is still running here, so a late request skips the wake phase.
            if (wake_req) begin
               state_d    = CG_ON;
               idle_cnt_d = idle_thresh;
            end else begin
               state_d = CG_OFF;
            end
         end
         default: state_d = CG_OFF;
      endcase
   end

   always_comb begin
      gate_en_d = (state_d != CG_OFF);
      ack_d     = (state_q == CG_ON) ? req : '0;
      gate_en   = gate_en_q;
      ack       = ack_q;
      cg_state  = state_q;
   end

`ifdef CLKGATE_STATS_EN
   dma_cg_stat_cnt #(
      .W (STAT_W)
   ) u_off_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (stat_clr),
      .inc   (~gate_en_q),
      .cnt   (off_cycles)
   );
`else
   logic unused_stat_clr;
   assign unused_stat_clr = stat_clr;
   assign off_cycles      = '0;
`endif

endmodule

// File: tb/tb_dma_clk_gate_ctrl.sv
// Directed bench for dma_clk_gate_ctrl: vector table for wake/gate-off, sequences for corners.
module tb_dma_clk_gate_ctrl;
   import dma_cg_pkg::*;

   localparam int unsigned NReq = 4;
   localparam int unsigned CntW = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NReq-1:0] req;
   logic [NReq-1:0] busy;
   logic            force_on;
   logic [CntW-1:0] idle_thresh;
   logic [NReq-1:0] ack;
   logic            gate_en;
   logic [1:0]      cg_state;
   logic            stat_clr;
   logic [31:0]     off_cycles;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0] req;
      logic [3:0] busy;
      logic       force_on;
      logic [1:0] exp_state;
      logic       exp_gate;
      logic [3:0] exp_ack;
   } vec_t;

   vec_t vecs[17];

   dma_clk_gate_ctrl #(
      .N_REQ    (NReq),
      .CNT_W    (CntW),
      .WAKE_CYC (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .busy        (busy),
      .force_on    (force_on),
      .idle_thresh (idle_thresh),
      .ack         (ack),
      .gate_en     (gate_en),
      .cg_state    (cg_state),
      .stat_clr    (stat_clr),
      .off_cycles  (off_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic [1:0] st, input logic ge,
                          input logic [3:0] ak);
      chk({name, ".state"}, 32'(cg_state), 32'(st));
      chk({name, ".gate_en"}, 32'(gate_en), 32'(ge));
      chk({name, ".ack"}, 32'(ack), 32'(ak));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input string name, input logic [1:0] target, input int max_cyc);
      int k = 0;
      while (cg_state !== target && k < max_cyc) begin
         step();
         k++;
      end
      chk(name, 32'(cg_state), 32'(target));
   endtask

   initial begin
      // Cycle-by-cycle: wake, ack, idle gate-off (WAKE_CYC=4, idle_thresh=3).
      vecs[0]  = '{4'h1, 4'h0, 1'b0, CG_OFF,   1'b0, 4'h0};
      vecs[1]  = '{4'h1, 4'h0, 1'b0, CG_WAKE,  1'b1, 4'h0};
      vecs[2]  = '{4'h1, 4'h0, 1'b0, CG_WAKE,  1'b1, 4'h0};
      vecs[3]  = '{4'h1, 4'h0, 1'b0, CG_WAKE,  1'b1, 4'h0};
      vecs[4]  = '{4'h1, 4'h0, 1'b0, CG_WAKE,  1'b1, 4'h0};
      vecs[5]  = '{4'h1, 4'h0, 1'b0, CG_ON,    1'b1, 4'h0};
      vecs[6]  = '{4'h1, 4'h0, 1'b0, CG_ON,    1'b1, 4'h1};
      vecs[7]  = '{4'h1, 4'h0, 1'b0, CG_ON,    1'b1, 4'h1};
      vecs[8]  = '{4'h1, 4'h0, 1'b0, CG_ON,    1'b1, 4'h1};
      vecs[9]  = '{4'h1, 4'h0, 1'b0, CG_ON,    1'b1, 4'h1};
      vecs[10] = '{4'h0, 4'h0, 1'b0, CG_ON,    1'b1, 4'h1};
      vecs[11] = '{4'h0, 4'h0, 1'b0, CG_ON,    1'b1, 4'h0};
      vecs[12] = '{4'h0, 4'h0, 1'b0, CG_ON,    1'b1, 4'h0};
      vecs[13] = '{4'h0, 4'h0, 1'b0, CG_ON,    1'b1, 4'h0};
      vecs[14] = '{4'h0, 4'h0, 1'b0, CG_DRAIN, 1'b1, 4'h0};
      vecs[15] = '{4'h0, 4'h0, 1'b0, CG_OFF,   1'b0, 4'h0};
      vecs[16] = '{4'h0, 4'h0, 1'b0, CG_OFF,   1'b0, 4'h0};

      rst_n       = 1'b0;
      req         = '0;
      busy        = '0;
      force_on    = 1'b0;
      idle_thresh = 8'd3;
      stat_clr    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset", CG_OFF, 1'b0, 4'h0);
      chk("reset.off_cycles", off_cycles, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         req      = vecs[i].req;
         busy     = vecs[i].busy;
         force_on = vecs[i].force_on;
         chk_out($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_gate, vecs[i].exp_ack);
         step();
      end

      // force_on rising on the cycle the idle counter reaches 0 blocks DRAIN.
      req = 4'h1;
      wait_state("fblk.wake_to_on", CG_ON, 12);
      step();
      req = 4'h0;
      for (int k = 0; k < 3; k++) begin
         chk("fblk.idle_on", 32'(cg_state), 32'(CG_ON));
         step();
      end
      force_on = 1'b1;
      chk("fblk.last_idle_on", 32'(cg_state), 32'(CG_ON));
      step();
      chk("fblk.no_drain", 32'(cg_state), 32'(CG_ON));

      // busy holds the clock on with no requests.
      force_on = 1'b0;
      busy     = 4'b0100;
      for (int k = 0; k < 20; k++) begin
         chk_out("busy_hold", CG_ON, 1'b1, 4'h0);
         step();
      end
      busy = 4'h0;
      for (int k = 0; k < 4; k++) begin
         chk("busy_release.on", 32'(cg_state), 32'(CG_ON));
         step();
      end
      chk_out("busy_release.drain", CG_DRAIN, 1'b1, 4'h0);

      // Re-request during DRAIN returns to ON without a wake.
      req = 4'b1000;
      step();
      chk_out("drain_rereq.on", CG_ON, 1'b1, 4'h0);
      step();
      chk_out("drain_rereq.ack", CG_ON, 1'b1, 4'b1000);
      req = 4'h0;
      for (int k = 0; k < 4; k++) begin
         chk("drain_rereq.gate_en", 32'(gate_en), 32'd1);
         step();
      end
      chk_out("drain_rereq.drain", CG_DRAIN, 1'b1, 4'h0);
      step();
      chk_out("drain_rereq.off", CG_OFF, 1'b0, 4'h0);

      // force_on with idle_thresh=0.
      idle_thresh = 8'd0;
      force_on    = 1'b1;
      wait_state("force.wake_to_on", CG_ON, 12);
      for (int k = 0; k < 30; k++) begin
         chk_out("force.hold", CG_ON, 1'b1, 4'h0);
         step();
      end
      force_on = 1'b0;
      chk("force.release_on", 32'(cg_state), 32'(CG_ON));
      step();
      chk_out("force.drain", CG_DRAIN, 1'b1, 4'h0);
      step();
      chk_out("force.off", CG_OFF, 1'b0, 4'h0);

      // Asynchronous reset in the middle of WAKE.
      idle_thresh = 8'd3;
      req         = 4'b0010;
      step();
      step();
      chk_out("rst_wake.pre", CG_WAKE, 1'b1, 4'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("rst_wake.now", CG_OFF, 1'b0, 4'h0);
      req = 4'h0;
      @(posedge clk);
      #1;
      chk("stats.reset", off_cycles, 32'd0);
      rst_n = 1'b1;
      repeat (100) step();
`ifdef CLKGATE_STATS_EN
      chk("stats.count100", off_cycles, 32'd100);
`else
      chk("stats.tied0", off_cycles, 32'd0);
`endif
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      chk("stats.clear", off_cycles, 32'd0);
      step();
`ifdef CLKGATE_STATS_EN
      chk("stats.after_clear", off_cycles, 32'd1);
`else
      chk("stats.after_clear", off_cycles, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
